// File: rtl/alu_cmd_issuer.sv
// Command-side master for the 8-bit ALU: buffers tagged commands, issues them one at a time,
// screens illegal/div-by-zero commands, times out a silent ALU and returns tagged responses in order.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_fn_i,
    input  logic [7:0]       cmd_op1_i,
    input  logic [7:0]       cmd_op2_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic             alu_enable_o,
    output logic [2:0]       alu_fn_o,
    output logic [7:0]       alu_op1_o,
    output logic [7:0]       alu_op2_o,
    input  logic [15:0]      alu_result_i,
    input  logic             alu_valid_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic [2:0]       fn;
        logic [7:0]       op1;
        logic [7:0]       op2;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    cmd_t              mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    cmd_t              head_c;
    logic              push_c, pop_c, bad_cmd_c;

    state_t            state_q;
    logic [TMO_W-1:0]  tmo_q, tmo_inc_c;
    logic              alu_enable_q;
    logic [2:0]        alu_fn_q;
    logic [7:0]        alu_op1_q, alu_op2_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [15:0]       rsp_data_q;
    logic [TAG_W-1:0]  rsp_tag_q;

    assign cmd_ready_o = (count_q != CNT_W'(DEPTH));
    assign push_c      = cmd_valid_i && cmd_ready_o;
    assign pop_c       = rsp_valid_q && rsp_ready_i;
    assign head_c      = mem_q[rd_ptr_q];
    assign bad_cmd_c   = (head_c.fn > 3'd5) || ((head_c.fn == 3'd3) && (head_c.op2 == 8'd0));
    assign tmo_inc_c   = tmo_q + TMO_W'(1);

    // Command storage; the head is only released once its response is accepted
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{fn: cmd_fn_i, op1: cmd_op1_i, op2: cmd_op2_i, tag: cmd_tag_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Issue FSM; alu_enable is raised on entry to ISSUE so the pulse spans exactly that state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tmo_q        <= '0;
            alu_enable_q <= 1'b0;
            alu_fn_q     <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            alu_enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) state_q <= CHECK;
                end
                CHECK: begin
                    if (bad_cmd_c) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_tag_q   <= head_c.tag;
                        state_q     <= RESP;
                    end else begin
                        alu_enable_q <= 1'b1;
                        alu_fn_q     <= head_c.fn;
                        alu_op1_q    <= head_c.op1;
                        alu_op2_q    <= head_c.op2;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (alu_valid_i) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= alu_result_i;
                        rsp_tag_q   <= head_c.tag;
                        state_q     <= RESP;
                    end else begin
                        tmo_q <= tmo_inc_c;
                        if (tmo_inc_c == TMO_W'(TIMEOUT)) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_tag_q   <= head_c.tag;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_enable_o = alu_enable_q;
    assign alu_fn_o     = alu_fn_q;
    assign alu_op1_o    = alu_op1_q;
    assign alu_op2_o    = alu_op2_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a registered 1-cycle ALU model and hand-computed results.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_fn_i;
    logic [7:0]  cmd_op1_i, cmd_op2_i;
    logic [3:0]  cmd_tag_i;
    logic        alu_enable_o;
    logic [2:0]  alu_fn_o;
    logic [7:0]  alu_op1_o, alu_op2_o;
    logic [15:0] alu_result_i;
    logic        alu_valid_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_data_o;
    logic [3:0]  rsp_tag_o;
    logic        rsp_err_o;
    logic        busy_o;

    logic        alu_mute  = 1'b0;
    logic        alu_stray = 1'b0;
    logic        alu_valid_q = 1'b0;
    logic [15:0] alu_result_q = 16'd0;
    int          en_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    alu_cmd_issuer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_fn_i(cmd_fn_i), .cmd_op1_i(cmd_op1_i), .cmd_op2_i(cmd_op2_i), .cmd_tag_i(cmd_tag_i),
        .alu_enable_o(alu_enable_o), .alu_fn_o(alu_fn_o), .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o),
        .alu_result_i(alu_result_i), .alu_valid_i(alu_valid_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Registered ALU: result and valid one cycle after the enable pulse
    always @(posedge clk) begin
        alu_valid_q <= alu_enable_o && !alu_mute;
        case (alu_fn_o)
            3'd0:    alu_result_q <= {8'd0, alu_op1_o} + {8'd0, alu_op2_o};
            3'd1:    alu_result_q <= {8'd0, alu_op1_o} - {8'd0, alu_op2_o};
            3'd2:    alu_result_q <= {8'd0, alu_op1_o} * {8'd0, alu_op2_o};
            3'd3:    alu_result_q <= (alu_op2_o != 8'd0) ? {8'd0, alu_op1_o / alu_op2_o} : 16'd0;
            3'd4:    alu_result_q <= {8'd0, alu_op1_o & alu_op2_o};
            3'd5:    alu_result_q <= {8'd0, alu_op1_o | alu_op2_o};
            default: alu_result_q <= 16'd0;
        endcase
    end
    assign alu_valid_i  = alu_valid_q | alu_stray;
    assign alu_result_i = alu_result_q;

    always @(negedge clk) if (alu_enable_o === 1'b1) en_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL push_ready tag=%0d got %b exp 1", tag, cmd_ready_o);
        end
        cmd_valid_i = 1'b1;
        cmd_fn_i    = fn;
        cmd_op1_i   = a;
        cmd_op2_i   = b;
        cmd_tag_i   = tag;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int lat);
        lat = 0;
        while (rsp_valid_o !== 1'b1 && lat < limit) begin
            tick();
            lat++;
        end
        checks++;
        if (rsp_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rsp_wait got no rsp_valid after %0d cycles exp response", lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_ready_o, alu_enable_o, rsp_valid_o, rsp_err_o, busy_o} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got rdy/en/vld/err/busy=%b exp 10000",
                     {cmd_ready_o, alu_enable_o, rsp_valid_o, rsp_err_o, busy_o});
        end
        checks++;
        if ({alu_fn_o, alu_op1_o, alu_op2_o, rsp_data_o, rsp_tag_o} !== 39'd0) begin
            errors++;
            $display("FAIL reset_data got fn=%h op1=%h op2=%h data=%h tag=%h exp all 0",
                     alu_fn_o, alu_op1_o, alu_op2_o, rsp_data_o, rsp_tag_o);
        end
        alu_stray = 1'b1;
        tick();
        tick();
        alu_stray = 1'b0;
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle got vld=%b busy=%b exp 0 0", rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_add();
        int lat;
        en_cnt = 0;
        push(3'd0, 8'd200, 8'd100, 4'd3);
        wait_rsp(10, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL add_latency got %0d exp 4", lat);
        end
        checks++;
        if (rsp_data_o !== 16'd300 || rsp_tag_o !== 4'd3 || rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp got data=%0d tag=%0d err=%b exp 300 3 0",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
        checks++;
        if (rsp_valid_o !== 1'b0 || en_cnt != 1) begin
            errors++;
            $display("FAIL add_done got vld=%b pulses=%0d exp 0 1", rsp_valid_o, en_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        push(3'd2, 8'd255, 8'd255, 4'd1);
        push(3'd3, 8'd100, 8'd7, 4'd2);
        wait_rsp(12, lat);
        checks++;
        if (rsp_data_o !== 16'd65025 || rsp_tag_o !== 4'd1 || rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL mul_rsp got data=%0d tag=%0d err=%b exp 65025 1 0",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
        wait_rsp(12, lat);
        checks++;
        if (rsp_data_o !== 16'd14 || rsp_tag_o !== 4'd2 || rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL div_rsp got data=%0d tag=%0d err=%b exp 14 2 0",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
    endtask

    task automatic test_errors();
        int lat;
        en_cnt = 0;
        push(3'd3, 8'd9, 8'd0, 4'd5);
        wait_rsp(10, lat);
        checks++;
        if (rsp_data_o !== 16'd0 || rsp_tag_o !== 4'd5 || rsp_err_o !== 1'b1) begin
            errors++;
            $display("FAIL div0_rsp got data=%0d tag=%0d err=%b exp 0 5 1",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
        push(3'd7, 8'd1, 8'd2, 4'd6);
        wait_rsp(10, lat);
        checks++;
        if (rsp_data_o !== 16'd0 || rsp_tag_o !== 4'd6 || rsp_err_o !== 1'b1) begin
            errors++;
            $display("FAIL badfn_rsp got data=%0d tag=%0d err=%b exp 0 6 1",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
        checks++;
        if (en_cnt != 0) begin
            errors++;
            $display("FAIL err_no_enable got pulses=%0d exp 0", en_cnt);
        end
        push(3'd1, 8'd3, 8'd5, 4'd7);
        wait_rsp(10, lat);
        checks++;
        if (rsp_data_o !== 16'hFFFE || rsp_tag_o !== 4'd7 || rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL sub_wrap got data=%h tag=%0d err=%b exp fffe 7 0",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic seen;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(3'd0, 8'(i), 8'd1, 4'(8 + i));
        checks++;
        if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL full got rdy=%b busy=%b exp 0 1", cmd_ready_o, busy_o);
        end
        cmd_valid_i = 1'b1;
        cmd_fn_i    = 3'd0;
        cmd_op1_i   = 8'd50;
        cmd_op2_i   = 8'd50;
        cmd_tag_i   = 4'd15;
        wait_rsp(10, lat);
        tick();
        tick();
        tick();
        cmd_valid_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_data_o !== 16'd1 || rsp_tag_o !== 4'd8 ||
            rsp_err_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hold got vld=%b data=%0d tag=%0d err=%b rdy=%b exp 1 1 8 0 0",
                     rsp_valid_o, rsp_data_o, rsp_tag_o, rsp_err_o, cmd_ready_o);
        end
        rsp_ready_i = 1'b1;
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_pop got rdy=%b vld=%b exp 1 0", cmd_ready_o, rsp_valid_o);
        end
        for (int i = 1; i < 4; i++) begin
            wait_rsp(12, lat);
            checks++;
            if (rsp_data_o !== 16'(i + 1) || rsp_tag_o !== 4'(8 + i) || rsp_err_o !== 1'b0) begin
                errors++;
                $display("FAIL drain%0d got data=%0d tag=%0d err=%b exp %0d %0d 0",
                         i, rsp_data_o, rsp_tag_o, rsp_err_o, i + 1, 8 + i);
            end
            tick();
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid_o === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL no_extra got extra=%b busy=%b exp 0 0", seen, busy_o);
        end
    endtask

    task automatic test_timeout();
        int lat;
        alu_mute = 1'b1;
        push(3'd0, 8'd1, 8'd1, 4'd12);
        push(3'd0, 8'd2, 8'd2, 4'd13);
        wait_rsp(40, lat);
        checks++;
        if (lat != 17 || rsp_data_o !== 16'd0 || rsp_tag_o !== 4'd12 || rsp_err_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout got lat=%0d data=%0d tag=%0d err=%b exp 17 0 12 1",
                     lat, rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        alu_mute = 1'b0;
        tick();
        wait_rsp(12, lat);
        checks++;
        if (rsp_data_o !== 16'd4 || rsp_tag_o !== 4'd13 || rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout got data=%0d tag=%0d err=%b exp 4 13 0",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        logic seen;
        alu_mute = 1'b1;
        push(3'd0, 8'd5, 8'd5, 4'd14);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({cmd_ready_o, alu_enable_o, rsp_valid_o, rsp_err_o, busy_o} !== 5'b10000 ||
            {alu_fn_o, alu_op1_o, alu_op2_o, rsp_data_o, rsp_tag_o} !== 39'd0) begin
            errors++;
            $display("FAIL mid_reset got rdy/en/vld/err/busy=%b fn=%h op1=%h op2=%h data=%h tag=%h exp 10000 and zeros",
                     {cmd_ready_o, alu_enable_o, rsp_valid_o, rsp_err_o, busy_o},
                     alu_fn_o, alu_op1_o, alu_op2_o, rsp_data_o, rsp_tag_o);
        end
        alu_stray = 1'b1;
        tick();
        alu_stray = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL late_valid got activity=%b exp 0", seen);
        end
        alu_mute = 1'b0;
        push(3'd4, 8'hF0, 8'h3C, 4'd2);
        wait_rsp(10, lat);
        checks++;
        if (rsp_data_o !== 16'h0030 || rsp_tag_o !== 4'd2 || rsp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL and_after_reset got data=%h tag=%0d err=%b exp 0030 2 0",
                     rsp_data_o, rsp_tag_o, rsp_err_o);
        end
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_fn_i    = 3'd0;
        cmd_op1_i   = 8'd0;
        cmd_op2_i   = 8'd0;
        cmd_tag_i   = 4'd0;
        rsp_ready_i = 1'b1;
        test_reset();
        test_add();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
